// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the program loader and the core that fetches from it.
//   - state_e      : loader FSM state encoding (CHECK/ERR used only when the
//                    PROG_LOADER_CSUM_EN build option is defined)
//   - NOP_INSTR    : instruction word driven to the core when it is not running
//                    (MOV r0,r0)
//   - DEFAULT_*    : program memory geometry and PC width shared with the core
package prog_loader_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = 4;
  localparam int DEFAULT_PCW   = 5;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/prog_loader_ram.sv
// prog_ram
//   DEPTH x 8 program memory. One synchronous write port, one combinational
//   (zero-latency) read port so the core sees its instruction in the same
//   cycle it presents the PC. Contents are not reset.
//   Ports:
//     clk        in   clock
//     wr_en_i    in   write strobe
//     wr_addr_i  in   write address
//     wr_data_i  in   write data
//     rd_addr_i  in   read address
//     rd_data_o  out  read data (combinational)
module prog_ram
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Owns the writable program RAM of the core. A host streams a program image
//   in byte by byte (valid/ready); the core is held in reset while the image
//   is loaded and released once the final word has been written.
//   Build option: PROG_LOADER_CSUM_EN adds a trailing XOR checksum byte after
//   the image (CHECK state) and an error state (ERR) with a csum_err output.
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous active-low reset
//     ld_start   in   one-cycle pulse, start a new image load
//     ld_len     in   image length in words (0 or > DEPTH means DEPTH)
//     ld_valid   in   host byte valid
//     ld_data    in   host byte {op[4:0],sss[2:0]}
//     ld_ready   out  loader accepts a byte this cycle
//     cpu_addr   in   core PC (only the low AW bits address the RAM)
//     instr      out  instruction to the core, NOP unless running
//     cpu_reset  out  active-low core reset
//     busy       out  load in progress
//     loaded     out  words written by the last/current load
//     csum_err   out  checksum mismatch (PROG_LOADER_CSUM_EN only)
//   Requires PCW > AW.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW,
  parameter int PCW   = DEFAULT_PCW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ld_start,
  input  logic [AW:0]    ld_len,
  input  logic           ld_valid,
  input  logic [7:0]     ld_data,
  output logic           ld_ready,
  input  logic [PCW-1:0] cpu_addr,
  output logic [7:0]     instr,
  output logic           cpu_reset,
  output logic           busy,
  output logic [AW:0]    loaded
`ifdef PROG_LOADER_CSUM_EN
  ,
  output logic           csum_err
`endif
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   loaded_q, loaded_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [AW:0]   len_norm;
  logic          wr_en;
  logic [7:0]    rd_data;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  // The PC is wider than the RAM address; the upper bits simply wrap.
  logic unused_pc_bits;
  assign unused_pc_bits = ^cpu_addr[PCW-1:AW];

  assign len_norm = (ld_len == '0 || ld_len > DEPTH_W) ? DEPTH_W : ld_len;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= '0;
      loaded_q    <= '0;
      remaining_q <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      loaded_q    <= loaded_d;
      remaining_q <= remaining_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state logic. ld_start wins over everything, including a byte
  // offered in the same cycle, so a restart never writes stale data.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    loaded_d    = loaded_q;
    remaining_d = remaining_q;
    wr_en       = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    if (ld_start) begin
      state_d     = ST_LOAD;
      wr_ptr_d    = '0;
      loaded_d    = '0;
      remaining_d = len_norm;
`ifdef PROG_LOADER_CSUM_EN
      csum_d      = '0;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_valid && ld_ready) begin
            wr_en       = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            loaded_d    = loaded_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
`ifdef PROG_LOADER_CSUM_EN
            csum_d      = csum_q ^ ld_data;
            if (remaining_q == (AW+1)'(1)) state_d = ST_CHECK;
`else
            if (remaining_q == (AW+1)'(1)) state_d = ST_RUN;
`endif
          end
        end
`ifdef PROG_LOADER_CSUM_EN
        ST_CHECK: begin
          if (ld_valid && ld_ready) begin
            state_d = (ld_data == csum_q) ? ST_RUN : ST_ERR;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs are pure functions of the state (plus the RAM read in RUN).
  always_comb begin
    ld_ready  = 1'b0;
    busy      = 1'b0;
    cpu_reset = 1'b0;
    instr     = NOP_INSTR;
`ifdef PROG_LOADER_CSUM_EN
    csum_err  = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_RUN: begin
        cpu_reset = 1'b1;
        instr     = rd_data;
      end
`ifdef PROG_LOADER_CSUM_EN
      ST_CHECK: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_ERR: begin
        csum_err = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign loaded = loaded_q;

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (ld_data),
    .rd_addr_i (cpu_addr[AW-1:0]),
    .rd_data_o (rd_data)
  );

endmodule
